// File: rtl/char_scroll_pkg.sv
// Shared types and constants for the character scroller and its timing helpers.
// Contents: code width, default blank code, divider run/hold state, scroll
// direction encodings.
package char_scroll_pkg;

  localparam int CODE_W = 4;

  // Code the per-digit decoders render as an unlit digit.
  localparam logic [CODE_W-1:0] DEFAULT_BLANK_CODE = 4'hF;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/char_scroller_if.sv
// Control/data bundle between a message source and the character scroller.
//   en, dir              : scroll enable and direction
//   load_we/addr/data    : message buffer write port
//   codes                : packed registered digit codes, digit 0 in [3:0]
//   step                 : one-cycle pulse per scroll step
//   head                 : current window start index
// master drives control and write port; slave (the scroller) drives outputs.
interface char_scroller_if
  import char_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                         en;
  logic                         dir;
  logic                         load_we;
  logic [3:0]                   load_addr;
  logic [CODE_W-1:0]            load_data;
  logic [CODE_W*NUM_DIGITS-1:0] codes;
  logic                         step;
  logic [3:0]                   head;

  modport master (
    output en, dir, load_we, load_addr, load_data,
    input  codes, step, head
  );

  modport slave (
    input  en, dir, load_we, load_addr, load_data,
    output codes, step, head
  );

endinterface

// File: rtl/rate_divider.sv
// Programmable rate divider shared by the timed display blocks.
//   Clock  : system clock
//   Reset  : synchronous active-high reset
//   en     : 1 = count, 0 = hold count
//   pulse  : registered one-cycle pulse on each wrap of the 0..TICK_DIV-1 count
module rate_divider
  import char_scroll_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  output logic pulse
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  // Outputs follow the state being entered so a change of en acts on the
  // same edge; the retained count means no step is lost or repeated.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (state_d == RUN) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/char_scroller.sv
// Character scroller: holds a MSG_LEN-entry message of 4-bit codes and shows a
// NUM_DIGITS-wide window of it, rotating the window once per scroll step.
//   Clock, Reset : system clock, synchronous active-high reset
//   bus (slave)  : en/dir control, buffer write port, codes/step/head outputs
//   blink        : only with CHAR_SCROLLER_BLINK_EN defined; 1 = toggle an
//                  all-blank display phase on every step
// Optional feature macro: CHAR_SCROLLER_BLINK_EN.
module char_scroller
  import char_scroll_pkg::*;
#(
  parameter int                NUM_DIGITS = 4,
  parameter int                MSG_LEN    = 8,
  parameter int                TICK_DIV   = 50000000,
  parameter logic [CODE_W-1:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
  input  logic            Clock,
  input  logic            Reset,
`ifdef CHAR_SCROLLER_BLINK_EN
  input  logic            blink,
`endif
  char_scroller_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
  localparam int         OUT_W    = CODE_W * NUM_DIGITS;

  logic [CODE_W-1:0] buf_q [MSG_LEN];
  logic [CODE_W-1:0] buf_d [MSG_LEN];
  logic [3:0]        head_q, head_d;
  logic [OUT_W-1:0]  codes_q, codes_d;
  logic [OUT_W-1:0]  window;
  logic              step;
`ifdef CHAR_SCROLLER_BLINK_EN
  logic              phase_q, phase_d;
`endif

  rate_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .Clock(Clock),
    .Reset(Reset),
    .en   (bus.en),
    .pulse(step)
  );

  // Head moves on the edge where step is high; dir matters only then.
  always_comb begin
    head_d = head_q;
    if (step) begin
      if (bus.dir == DIR_UP) begin
        head_d = (head_q == LAST_IDX) ? 4'd0 : head_q + 4'd1;
      end else begin
        head_d = (head_q == 4'd0) ? LAST_IDX : head_q - 4'd1;
      end
    end
  end

  // Out-of-range addresses match no entry and are dropped.
  always_comb begin
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      buf_d[i] = buf_q[i];
      if (bus.load_we && (bus.load_addr == 4'(i))) begin
        buf_d[i] = bus.load_data;
      end
    end
  end

  // head < MSG_LEN and k < MSG_LEN, so one conditional subtract is the modulo.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    window = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = 32'(head_q) + k;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      window[CODE_W*k +: CODE_W] = BLANK_CODE;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        if (idx == i) window[CODE_W*k +: CODE_W] = buf_q[i];
      end
    end
  end

`ifdef CHAR_SCROLLER_BLINK_EN
  always_comb begin
    phase_d = phase_q;
    if (step) phase_d = blink ? ~phase_q : 1'b0;
    codes_d = phase_q ? {NUM_DIGITS{BLANK_CODE}} : window;
  end
`else
  always_comb begin
    codes_d = window;
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) buf_q[i] <= BLANK_CODE;
      head_q  <= '0;
      codes_q <= {NUM_DIGITS{BLANK_CODE}};
`ifdef CHAR_SCROLLER_BLINK_EN
      phase_q <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < MSG_LEN; i++) buf_q[i] <= buf_d[i];
      head_q  <= head_d;
      codes_q <= codes_d;
`ifdef CHAR_SCROLLER_BLINK_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign bus.codes = codes_q;
  assign bus.step  = step;
  assign bus.head  = head_q;

endmodule
